fc_acc_requant: RTL

- Downstream consumer of the FC-layer 16s x 16s -> 32-bit signed product stream.
- Accumulates NUM_IN products per output neuron, starting from a per-neuron bias.
- Rounds, right-shifts, optionally applies ReLU and saturates each neuron result to 16-bit signed.
- Emits one result per neuron on a valid/ready stream feeding the next layer's activation buffer.

---
 rtl/fc_acc_requant.sv | 116 +++++++++++
 1 files changed

// File: rtl/fc_acc_requant.sv
// FC-layer accumulator: sums NUM_IN signed products onto a per-neuron bias, then
// rounds, shifts, saturates (optionally ReLU) and streams one result per neuron.
module fc_acc_requant #(
  parameter int unsigned NUM_IN  = 120,
  parameter int unsigned NUM_OUT = 84,
  parameter int unsigned PROD_W  = 32,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned RELU    = 1,
  parameter int unsigned OUT_W   = 16,
  localparam int unsigned IDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] bias_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  localparam int unsigned CNT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned RW    = ACC_W + 1;
  localparam logic signed [RW-1:0] RND  = (RW'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_ACC, S_FIN, S_OUT} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         neuron;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [RW-1:0]     rnd_sum;
  logic signed [RW-1:0]     shifted;
  logic [OUT_W-1:0]         req;

  // Next accumulator value: the first product of a neuron starts from its bias.
  always_comb begin
    prod_ext = ACC_W'($signed(in_data));
    bias_ext = ACC_W'($signed(bias_data));
    acc_sum  = ((cnt == '0) ? bias_ext : acc) + prod_ext;
  end

  // Round half toward +inf, arithmetic shift, saturate, optional ReLU.
  always_comb begin
    rnd_sum = RW'(acc) + RND;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > MAXV)
      req = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shifted < MINV)
      req = {1'b1, {(OUT_W-1){1'b0}}};
    else
      req = shifted[OUT_W-1:0];
    if ((RELU != 0) && req[OUT_W-1])
      req = '0;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= S_ACC;
      cnt       <= '0;
      acc       <= '0;
      neuron    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid && in_ready) begin
            acc <= acc_sum;
            if (cnt == CNT_W'(NUM_IN - 1)) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= S_FIN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_FIN: begin
          out_data  <= req;
          out_idx   <= neuron;
          out_last  <= (neuron == IDX_W'(NUM_OUT - 1));
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          // Result held stable until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            neuron    <= (neuron == IDX_W'(NUM_OUT - 1)) ? '0 : neuron + IDX_W'(1);
            in_ready  <= 1'b1;
            state     <= S_ACC;
          end
        end
        default: begin
          state    <= S_ACC;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
